// File: rtl/cps_line_buffer_mux.sv
// cps_line_buffer_mux: ping-pong tile line buffer for the CPS video path.
// The fetch sequencer writes tile-ROM words for the next line into the write
// bank while the previous line is scanned out of the read bank, one packed
// pixel per layer per PIX_CE. Words not written this line scan out as
// transparent (all ones).
module cps_line_buffer_mux #(
    parameter int NUM_LAYERS = 4,
    parameter int WORDS      = 64,
    parameter int PIX_BITS   = 4,
    parameter int WORD_BITS  = 32
) (
    input  logic                                          CLK_16M,
    input  logic                                          RESET_N,
    input  logic                                          LI,
    input  logic                                          PIX_CE,
    input  logic                                          WR_EN,
    input  logic [$clog2(NUM_LAYERS > 1 ? NUM_LAYERS : 2)-1:0] WR_LAYER,
    input  logic [$clog2(WORDS > 1 ? WORDS : 2)-1:0]      WR_ADDR,
    input  logic                                          WR_HFLIP,
    input  logic [WORD_BITS-1:0]                          WR_DATA,
    output logic [NUM_LAYERS*PIX_BITS-1:0]                PIX_OUT,
    output logic                                          PIX_VALID,
    output logic [$clog2(WORDS*(WORD_BITS/PIX_BITS)+1)-1:0] PIX_X,
    output logic                                          BUF_SEL,
    output logic                                          WR_ERR
);

    localparam int PPW      = WORD_BITS / PIX_BITS;
    localparam int LINE_PIX = WORDS * PPW;
    localparam int AW       = $clog2(WORDS > 1 ? WORDS : 2);
    localparam int XW       = $clog2(LINE_PIX + 1);
    localparam logic [XW-1:0] END_X = XW'(LINE_PIX);

    // Word storage and written-masks, indexed [bank][layer][word]
    logic [WORD_BITS-1:0] mem_q  [2][NUM_LAYERS][WORDS];
    logic [WORDS-1:0]     mask_q [2][NUM_LAYERS];

    // Read-side fetch register (one word and mask bit per layer)
    logic [WORD_BITS-1:0] rd_word_q [NUM_LAYERS];
    logic [NUM_LAYERS-1:0] rd_mask_q;

    // Control and output state
    logic                          buf_sel_q;
    logic                          scan_q;
    logic                          valid_q;
    logic                          wr_err_q;
    logic [XW-1:0]                 cnt_q;
    logic [XW-1:0]                 pix_x_q;
    logic [NUM_LAYERS*PIX_BITS-1:0] pix_out_q;

    // Combinational helpers
    logic                          wr_ok;
    logic [WORD_BITS-1:0]          wr_word;
    logic [AW-1:0]                 rd_idx;
    int                            rd_field;
    logic [WORD_BITS-1:0]          shifted;
    logic [NUM_LAYERS*PIX_BITS-1:0] scan_pix;

    // Qualify the write and build the stored word, pixel-reversed on HFLIP
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
        wr_ok   = WR_EN && (int'(WR_LAYER) < NUM_LAYERS) && (int'(WR_ADDR) < WORDS);
        wr_word = WR_DATA;
        if (WR_HFLIP) begin
            for (int i = 0; i < PPW; i++) begin
                wr_word[i*PIX_BITS +: PIX_BITS] = WR_DATA[(PPW-1-i)*PIX_BITS +: PIX_BITS];
            end
        end
    end

    // Word address and pixel field for the current counter, plus the pixels the next PIX_CE emits
    always_comb begin
        rd_idx   = '0;
        rd_field = int'(cnt_q) % PPW;
        shifted  = '0;
        scan_pix = '1;
        if (int'(cnt_q) / PPW < WORDS) begin
            rd_idx = AW'(int'(cnt_q) / PPW);
        end
        for (int k = 0; k < NUM_LAYERS; k++) begin
            shifted = rd_word_q[k] << (rd_field * PIX_BITS);
            if (rd_mask_q[k]) begin
                scan_pix[k*PIX_BITS +: PIX_BITS] = shifted[WORD_BITS-1 -: PIX_BITS];
            end
        end
    end

    // Word RAM write port into the current write bank
    // NOTE: the word RAM has no reset; the cleared written-masks alone make stale words read as transparent.
    always_ff @(posedge CLK_16M) begin
        if (wr_ok) begin
            mem_q[buf_sel_q][WR_LAYER][WR_ADDR] <= wr_word;
        end
    end

    // Fetch the read-bank word and mask bit for every layer each cycle
    always_ff @(posedge CLK_16M) begin
        for (int k = 0; k < NUM_LAYERS; k++) begin
            rd_word_q[k] <= mem_q[~buf_sel_q][k][rd_idx];
            rd_mask_q[k] <= mask_q[~buf_sel_q][k][rd_idx];
        end
    end

    // Written-masks: set on write, new write bank cleared on LI
    always_ff @(posedge CLK_16M or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < NUM_LAYERS; k++) begin
                    mask_q[b][k] <= '0;
                end
            end
        end else begin
            if (LI) begin
                for (int k = 0; k < NUM_LAYERS; k++) begin
                    mask_q[~buf_sel_q][k] <= '0;
                end
            end
            if (wr_ok) begin
                mask_q[buf_sel_q][WR_LAYER][WR_ADDR] <= 1'b1;
            end
        end
    end

    // Bank toggle, scan counter and registered pixel outputs
    always_ff @(posedge CLK_16M or negedge RESET_N) begin
        if (!RESET_N) begin
            buf_sel_q <= 1'b0;
            scan_q    <= 1'b0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            pix_x_q   <= '0;
            pix_out_q <= '1;
            wr_err_q  <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            wr_err_q <= WR_EN && !wr_ok;
            if (LI) begin
                buf_sel_q <= ~buf_sel_q;
                cnt_q     <= '0;
                scan_q    <= 1'b1;
                valid_q   <= 1'b0;
            end else if (PIX_CE && scan_q) begin
                if (cnt_q == END_X) begin
                    valid_q   <= 1'b0;
                    pix_out_q <= '1;
                    scan_q    <= 1'b0;
                end else begin
                    pix_out_q <= scan_pix;
                    valid_q   <= 1'b1;
                    pix_x_q   <= cnt_q;
                    cnt_q     <= cnt_q + XW'(1);
                end
            end
        end
    end

    assign PIX_OUT   = pix_out_q;
    assign PIX_VALID = valid_q;
    assign PIX_X     = pix_x_q;
    assign BUF_SEL   = buf_sel_q;
    assign WR_ERR    = wr_err_q;

endmodule

// File: tb/tb_cps_line_buffer_mux.sv
// Self-checking bench for cps_line_buffer_mux. A behavioural bank model
// predicts every scanned pixel; expectations are queued as each PIX_CE is
// driven and compared when the DUT presents the pixel. A second instance
// with 3 layers and 5 words covers unrepresentable-write rejection.
module tb_cps_line_buffer_mux;

    logic        CLK_16M = 1'b0;
    logic        RESET_N = 1'b0;

    // Main instance (defaults: 4 layers, 64 words, 4-bit pixels)
    logic        li = 1'b0, pix_ce = 1'b0, wr_en = 1'b0, wr_hflip = 1'b0;
    logic [1:0]  wr_layer = '0;
    logic [5:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [15:0] pix_out;
    logic        pix_valid, buf_sel, wr_err;
    logic [9:0]  pix_x;

    // Small instance (3 layers, 5 words)
    logic        li3 = 1'b0, pix_ce3 = 1'b0, wr_en3 = 1'b0;
    logic [2:0]  wr_addr3 = '0;
    logic [11:0] pix_out3;
    logic        pix_valid3, buf_sel3, wr_err3;
    logic [5:0]  pix_x3;

    int tests_run = 0;
    int tests_failed = 0;

    cps_line_buffer_mux dut (
        .CLK_16M(CLK_16M), .RESET_N(RESET_N), .LI(li), .PIX_CE(pix_ce),
        .WR_EN(wr_en), .WR_LAYER(wr_layer), .WR_ADDR(wr_addr), .WR_HFLIP(wr_hflip),
        .WR_DATA(wr_data), .PIX_OUT(pix_out), .PIX_VALID(pix_valid), .PIX_X(pix_x),
        .BUF_SEL(buf_sel), .WR_ERR(wr_err)
    );

    cps_line_buffer_mux #(.NUM_LAYERS(3), .WORDS(5)) dut3 (
        .CLK_16M(CLK_16M), .RESET_N(RESET_N), .LI(li3), .PIX_CE(pix_ce3),
        .WR_EN(wr_en3), .WR_LAYER(wr_layer), .WR_ADDR(wr_addr3), .WR_HFLIP(wr_hflip),
        .WR_DATA(wr_data), .PIX_OUT(pix_out3), .PIX_VALID(pix_valid3), .PIX_X(pix_x3),
        .BUF_SEL(buf_sel3), .WR_ERR(wr_err3)
    );

    always #5 CLK_16M = ~CLK_16M;

    // Reference model of both banks
    logic [31:0] m_data [2][4][64];
    bit          m_mask [2][4][64];
    bit          m_sel = 1'b0;

    typedef struct {
        bit          valid;
        int          x;
        logic [15:0] pix;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int          l;
        int          a;
        logic [31:0] d;
        bit          f;
    } wr_t;
    wr_t bg_q[$];

    logic [11:0] sb3[$];
    logic [15:0] line_cap [512];

    function automatic logic [31:0] rev_word(input logic [31:0] d);
        logic [31:0] r;
        for (int i = 0; i < 8; i++) r[i*4 +: 4] = d[(7-i)*4 +: 4];
        return r;
    endfunction

    function automatic logic [15:0] exp_pix(input int x);
        logic [15:0] p;
        logic [31:0] t;
        int rb;
        rb = m_sel ? 0 : 1;
        p  = 16'hFFFF;
        for (int k = 0; k < 4; k++) begin
            if (m_mask[rb][k][x/8]) begin
                t = m_data[rb][k][x/8];
                p[k*4 +: 4] = t[31 - 4*(x%8) -: 4];
            end
        end
        return p;
    endfunction

    task automatic cycle();
        @(posedge CLK_16M);
        #1;
    endtask

    task automatic model_write(input int l, input int a, input logic [31:0] d, input bit f);
        m_data[m_sel][l][a] = f ? rev_word(d) : d;
        m_mask[m_sel][l][a] = 1'b1;
    endtask

    task automatic wr(input int l, input int a, input logic [31:0] d, input bit f);
        wr_en = 1'b1; wr_layer = 2'(l); wr_addr = 6'(a); wr_data = d; wr_hflip = f;
        cycle();
        wr_en = 1'b0; wr_hflip = 1'b0;
        model_write(l, a, d, f);
        tests_run++;
        if (wr_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL wr_err_valid_write l=%0d a=%0d: got %b expected 0", l, a, wr_err);
        end
    endtask

    task automatic li_pulse(input bit with_wr, input int l, input int a, input logic [31:0] d);
        li = 1'b1;
        if (with_wr) begin
            wr_en = 1'b1; wr_layer = 2'(l); wr_addr = 6'(a); wr_data = d; wr_hflip = 1'b0;
        end
        cycle();
        li = 1'b0; wr_en = 1'b0;
        if (with_wr) model_write(l, a, d, 1'b0);
        m_sel = !m_sel;
        for (int k = 0; k < 4; k++)
            for (int w = 0; w < 64; w++) m_mask[m_sel][k][w] = 1'b0;
        tests_run++;
        if (pix_valid !== 1'b0 || buf_sel !== m_sel) begin
            tests_failed++;
            $display("FAIL li_response: got valid=%b buf_sel=%b expected valid=0 buf_sel=%b",
                     pix_valid, buf_sel, m_sel);
        end
        cycle();
    endtask

    task automatic strobe(input bit valid, input int x, input logic [15:0] pix);
        exp_t e;
        exp_t got;
        e.valid = valid; e.x = x; e.pix = pix;
        sb.push_back(e);
        pix_ce = 1'b1;
        cycle();
        pix_ce = 1'b0;
        got = sb.pop_front();
        tests_run++;
        if (pix_valid !== got.valid || pix_x !== 10'(got.x) || pix_out !== got.pix) begin
            tests_failed++;
            $display("FAIL pixel x=%0d: got valid=%b x=%0d pix=%h, expected valid=%b x=%0d pix=%h",
                     got.x, pix_valid, pix_x, pix_out, got.valid, got.x, got.pix);
        end
        if (valid) line_cap[x] = pix_out;
        if (bg_q.size() > 0) begin
            wr_t w;
            w = bg_q.pop_front();
            wr(w.l, w.a, w.d, w.f);
        end else begin
            cycle();
        end
    endtask

    task automatic scan_line(input int n, input bit full);
        for (int x = 0; x < n; x++) strobe(1'b1, x, exp_pix(x));
        if (full) begin
            strobe(1'b0, 511, 16'hFFFF);
            strobe(1'b0, 511, 16'hFFFF);
        end
    endtask

    task automatic spot(input string name, input int x, input int layer, input logic [3:0] e);
        tests_run++;
        if (line_cap[x][layer*4 +: 4] !== e) begin
            tests_failed++;
            $display("FAIL %s x=%0d layer=%0d: got %h expected %h", name, x, layer,
                     line_cap[x][layer*4 +: 4], e);
        end
    endtask

    task automatic test_reset();
        repeat (3) cycle();
        tests_run++;
        if (pix_out !== 16'hFFFF || pix_valid !== 1'b0 || pix_x !== 10'd0 ||
            buf_sel !== 1'b0 || wr_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: got out=%h valid=%b x=%0d sel=%b err=%b expected FFFF 0 0 0 0",
                     pix_out, pix_valid, pix_x, buf_sel, wr_err);
        end
        RESET_N = 1'b1;
        cycle();
        li_pulse(1'b0, 0, 0, '0);
        scan_line(512, 1'b1);
        spot("empty_line", 0, 0, 4'hF);
        spot("empty_line", 511, 3, 4'hF);
    endtask

    task automatic test_basic();
        wr(1, 0, 32'h0123_4567, 1'b0);
        li_pulse(1'b0, 0, 0, '0);
        scan_line(512, 1'b1);
        for (int i = 0; i < 8; i++) spot("basic_l1", i, 1, 4'(i));
        spot("basic_l0", 3, 0, 4'hF);
    endtask

    task automatic test_hflip();
        wr(1, 0, 32'h0123_4567, 1'b1);
        wr(1, 63, 32'h89AB_CDEF, 1'b0);
        li_pulse(1'b0, 0, 0, '0);
        scan_line(512, 1'b1);
        for (int i = 0; i < 8; i++) spot("hflip", i, 1, 4'(7 - i));
        for (int i = 0; i < 8; i++) spot("last_word", 504 + i, 1, 4'(8 + i));
    endtask

    task automatic test_ping_pong();
        bit sel_before;
        int addrs_a[4] = '{0, 17, 40, 63};
        int addrs_b[4] = '{0, 17, 33, 63};
        for (int l = 0; l < 4; l++)
            for (int i = 0; i < 4; i++) wr(l, addrs_a[i], $urandom, bit'($urandom_range(0, 1)));
        sel_before = m_sel;
        li_pulse(1'b0, 0, 0, '0);
        for (int l = 0; l < 4; l++)
            for (int i = 0; i < 4; i++) begin
                wr_t w;
                w.l = l; w.a = addrs_b[i]; w.d = $urandom; w.f = bit'($urandom_range(0, 1));
                bg_q.push_back(w);
            end
        scan_line(512, 1'b1);
        li_pulse(1'b0, 0, 0, '0);
        tests_run++;
        if (buf_sel !== sel_before) begin
            tests_failed++;
            $display("FAIL buf_sel_twice: got %b expected %b", buf_sel, sel_before);
        end
        scan_line(512, 1'b1);
        li_pulse(1'b0, 0, 0, '0);
        scan_line(512, 1'b1);
        spot("mask_cleared", 0, 2, 4'hF);
        spot("mask_cleared", 320, 0, 4'hF);
    endtask

    task automatic test_mid_scan_li();
        wr(2, 25, 32'h3C3C_3C3C, 1'b0);
        li_pulse(1'b0, 0, 0, '0);
        scan_line(201, 1'b0);
        li_pulse(1'b1, 2, 30, 32'hA5A5_5A5A);
        scan_line(512, 1'b1);
        spot("li_write", 240, 2, 4'hA);
        spot("li_write", 241, 2, 4'h5);
        spot("li_write", 244, 2, 4'h5);
        spot("li_write", 239, 2, 4'hF);
    endtask

    task automatic wr3(input int l, input int a, input logic [31:0] d, input bit exp_err);
        wr_en3 = 1'b1; wr_layer = 2'(l); wr_addr3 = 3'(a); wr_data = d; wr_hflip = 1'b0;
        cycle();
        wr_en3 = 1'b0;
        tests_run++;
        if (wr_err3 !== exp_err) begin
            tests_failed++;
            $display("FAIL wr_err3 l=%0d a=%0d: got %b expected %b", l, a, wr_err3, exp_err);
        end
        cycle();
        tests_run++;
        if (wr_err3 !== 1'b0) begin
            tests_failed++;
            $display("FAIL wr_err3_pulse l=%0d a=%0d: got %b expected 0", l, a, wr_err3);
        end
    endtask

    task automatic test_bad_write();
        logic [11:0] e;
        logic [11:0] got;
        wr3(2, 0, 32'h1111_2222, 1'b0);
        wr3(0, 4, 32'hFEDC_BA98, 1'b0);
        wr3(3, 0, 32'h0000_0000, 1'b1);
        wr3(0, 5, 32'h0000_0000, 1'b1);
        wr3(1, 7, 32'h0000_0000, 1'b1);
        li3 = 1'b1;
        cycle();
        li3 = 1'b0;
        tests_run++;
        if (pix_valid3 !== 1'b0 || buf_sel3 !== 1'b1) begin
            tests_failed++;
            $display("FAIL li3: got valid=%b sel=%b expected 0 1", pix_valid3, buf_sel3);
        end
        cycle();
        for (int x = 0; x < 40; x++) begin
            e = 12'hFFF;
            if (x >= 32) e[3:0] = 4'(15 - (x - 32));
            if (x < 8) e[11:8] = (x < 4) ? 4'h1 : 4'h2;
            sb3.push_back(e);
            pix_ce3 = 1'b1;
            cycle();
            pix_ce3 = 1'b0;
            got = sb3.pop_front();
            tests_run++;
            if (pix_out3 !== got || pix_valid3 !== 1'b1 || pix_x3 !== 6'(x)) begin
                tests_failed++;
                $display("FAIL small_pixel x=%0d: got valid=%b x=%0d pix=%h expected valid=1 pix=%h",
                         x, pix_valid3, pix_x3, pix_out3, got);
            end
            cycle();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_hflip();
        test_ping_pong();
        test_mid_scan_li();
        test_bad_write();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
